pa_spsram_arb: RTL and testbench

PA_SPSRAM_ARB -- requirements
Module: pa_spsram_arb

---
 rtl/pa_spsram_arb.sv | 140 ++++++++++++++
 tb/tb_pa_spsram_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_spsram_arb.sv
// Two-port round-robin arbiter in front of a single-port 8K x 32 SRAM.
// After reset or clr_req the whole array is zero-filled before any requester is granted.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | zero-fill: one word per cycle at cnt, grants blocked
// ST_IDLE | normal service: grant p0/p1 combinationally, round-robin on contention
module pa_spsram_arb #(
  parameter bit INIT_EN = 1'b1
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        clr_req,
  output logic        init_done,

  input  logic        p0_req_vld,
  input  logic [12:0] p0_req_addr,
  input  logic        p0_req_wr,
  input  logic [31:0] p0_req_wdata,
  input  logic [3:0]  p0_req_be,
  output logic        p0_req_grnt,
  output logic        p0_rsp_vld,
  output logic [31:0] p0_rsp_rdata,

  input  logic        p1_req_vld,
  input  logic [12:0] p1_req_addr,
  input  logic        p1_req_wr,
  input  logic [31:0] p1_req_wdata,
  input  logic [3:0]  p1_req_be,
  output logic        p1_req_grnt,
  output logic        p1_rsp_vld,
  output logic [31:0] p1_rsp_rdata,

  output logic [12:0] sram_a,
  output logic        sram_cen,
  output logic        sram_gwen,
  output logic [31:0] sram_wen,
  output logic [31:0] sram_d,
  input  logic [31:0] sram_q
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic        prio_q, prio_d;
  logic [1:0]  rd_pend_q, rd_pend_d;

  logic        sel_p1;
  logic [12:0] sel_addr;
  logic        sel_wr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic [31:0] sel_wen;

  // prio_q == 0 gives p0 the win on contention; it flips toward the other port on each grant
  assign sel_p1    = p1_req_grnt;
  assign sel_addr  = sel_p1 ? p1_req_addr  : p0_req_addr;
  assign sel_wr    = sel_p1 ? p1_req_wr    : p0_req_wr;
  assign sel_wdata = sel_p1 ? p1_req_wdata : p0_req_wdata;
  assign sel_be    = sel_p1 ? p1_req_be    : p0_req_be;
  assign sel_wen   = {{8{~sel_be[3]}}, {8{~sel_be[2]}}, {8{~sel_be[1]}}, {8{~sel_be[0]}}};

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      rd_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Outputs are gated by cpurst_b so the SRAM stays quiet while reset is held,
  // even though the state register already sits in ST_INIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    rd_pend_d   = 2'b00;
    p0_req_grnt = 1'b0;
    p1_req_grnt = 1'b0;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_a      = '0;
    sram_d      = '0;
    if (cpurst_b) begin
      unique case (state_q)
        ST_INIT: begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = cnt_q;
          cnt_d     = cnt_q + 13'd1;
          if (cnt_q == 13'h1FFF) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (p0_req_vld && (!p1_req_vld || !prio_q)) begin
            p0_req_grnt = 1'b1;
          end else if (p1_req_vld) begin
            p1_req_grnt = 1'b1;
          end
          if (p0_req_grnt || p1_req_grnt) begin
            sram_cen = 1'b0;
            sram_a   = sel_addr;
            sram_d   = sel_wdata;
            prio_d   = ~sel_p1;
            if (sel_wr) begin
              sram_gwen = 1'b0;
              sram_wen  = sel_wen;
            end
            rd_pend_d = {p1_req_grnt & ~sel_wr, p0_req_grnt & ~sel_wr};
          end
          // a read granted alongside clr_req still completes via rd_pend_q
          if (clr_req) begin
            state_d = ST_INIT;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign init_done    = (state_q == ST_IDLE);
  assign p0_rsp_vld   = rd_pend_q[0];
  assign p1_rsp_vld   = rd_pend_q[1];
  assign p0_rsp_rdata = rd_pend_q[0] ? sram_q : 32'h0;
  assign p1_rsp_rdata = rd_pend_q[1] ? sram_q : 32'h0;

endmodule

// File: tb/tb_pa_spsram_arb.sv
// Scoreboard bench for pa_spsram_arb: a driver issues requests and pushes the expected
// per-cycle pins and read responses; a negedge monitor pops and compares.
module tb_pa_spsram_arb;
  localparam bit INIT_EN = 1'b1;
  localparam int DEPTH   = 8192;

  logic        clk = 1'b0;
  logic        cpurst_b = 1'b1;
  logic        clr_req = 1'b0;
  logic        init_done;
  logic        p0_req_vld = 1'b0, p1_req_vld = 1'b0;
  logic [12:0] p0_req_addr = '0, p1_req_addr = '0;
  logic        p0_req_wr = 1'b0, p1_req_wr = 1'b0;
  logic [31:0] p0_req_wdata = '0, p1_req_wdata = '0;
  logic [3:0]  p0_req_be = '0, p1_req_be = '0;
  logic        p0_req_grnt, p1_req_grnt, p0_rsp_vld, p1_rsp_vld;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic [12:0] sram_a;
  logic        sram_cen, sram_gwen;
  logic [31:0] sram_wen, sram_d;
  logic [31:0] sram_q = '0;
  logic [31:0] sram_mem [DEPTH];

  pa_spsram_arb #(.INIT_EN(INIT_EN)) dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b), .clr_req(clr_req), .init_done(init_done),
    .p0_req_vld(p0_req_vld), .p0_req_addr(p0_req_addr), .p0_req_wr(p0_req_wr),
    .p0_req_wdata(p0_req_wdata), .p0_req_be(p0_req_be), .p0_req_grnt(p0_req_grnt),
    .p0_rsp_vld(p0_rsp_vld), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_vld(p1_req_vld), .p1_req_addr(p1_req_addr), .p1_req_wr(p1_req_wr),
    .p1_req_wdata(p1_req_wdata), .p1_req_be(p1_req_be), .p1_req_grnt(p1_req_grnt),
    .p1_rsp_vld(p1_rsp_vld), .p1_rsp_rdata(p1_rsp_rdata),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // single-port SRAM, 1-cycle read, per-bit active-low write enable
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  typedef struct {
    logic        vld;
    logic [12:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          cyc;
    logic        g0, g1, cen, gwen, done;
    logic [31:0] wen, d;
    logic [12:0] a;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  exp_t        exp_q[$];
  rsp_t        rq0[$], rq1[$];
  req_t        pend [2];
  logic [31:0] ref_mem [DEPTH];
  bit          model_idle;
  int          init_left, last_p, cyc_n;
  bit          rand_en = 1'b0, rst_lvl = 1'b0, clr_lvl = 1'b0;
  int          n_chk = 0, n_fail = 0;
  exp_t        mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", nm, c, act, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.vld = 1'b1;
    case ($urandom_range(0, 9))
      0:       r.addr = 13'h1FFF;
      1:       r.addr = 13'h0000;
      default: r.addr = 13'h40 + 13'($urandom_range(0, 63));
    endcase
    r.wr    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(0, 15));
    return r;
  endfunction

  task automatic model_reset();
    model_idle = (INIT_EN == 1'b0);
    init_left  = DEPTH;
    last_p     = 1;
    rq0.delete();
    rq1.delete();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic issue(input int p, input logic [12:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] be);
    pend[p].vld = 1'b1; pend[p].addr = a; pend[p].wr = wr; pend[p].wdata = wd; pend[p].be = be;
  endtask

  // one clock: drive inputs, advance the reference model, push the expectation
  task automatic do_cycle();
    exp_t e;
    rsp_t r;
    int   w;
    @(posedge clk);
    #1;
    cyc_n++;
    if (rand_en)
      for (int p = 0; p < 2; p++)
        if (!pend[p].vld && $urandom_range(0, 99) < 55) pend[p] = rand_req();
    cpurst_b = rst_lvl;
    clr_req  = clr_lvl;
    p0_req_vld = pend[0].vld; p0_req_addr = pend[0].addr; p0_req_wr = pend[0].wr;
    p0_req_wdata = pend[0].wdata; p0_req_be = pend[0].be;
    p1_req_vld = pend[1].vld; p1_req_addr = pend[1].addr; p1_req_wr = pend[1].wr;
    p1_req_wdata = pend[1].wdata; p1_req_be = pend[1].be;
    e.cyc = cyc_n; e.g0 = 1'b0; e.g1 = 1'b0; e.cen = 1'b1; e.gwen = 1'b1;
    e.wen = '1; e.a = '0; e.d = '0; e.done = 1'b0;
    if (!rst_lvl) begin
      model_reset();
      e.done = model_idle;
    end else if (!model_idle) begin
      e.cen = 1'b0; e.gwen = 1'b0; e.wen = '0;
      e.a = 13'(DEPTH - init_left);
      init_left--;
      if (init_left == 0) model_idle = 1'b1;
    end else begin
      e.done = 1'b1;
      w = -1;
      if (pend[0].vld && pend[1].vld) w = (last_p == 0) ? 1 : 0;
      else if (pend[0].vld)           w = 0;
      else if (pend[1].vld)           w = 1;
      if (w >= 0) begin
        e.g0 = (w == 0); e.g1 = (w == 1);
        e.cen = 1'b0; e.a = pend[w].addr; e.d = pend[w].wdata;
        if (pend[w].wr) begin
          e.gwen = 1'b0;
          e.wen  = ~be_mask(pend[w].be);
          ref_mem[pend[w].addr] = (ref_mem[pend[w].addr] & ~be_mask(pend[w].be)) |
                                  (pend[w].wdata & be_mask(pend[w].be));
        end else begin
          r.due  = cyc_n + 1;
          r.data = ref_mem[pend[w].addr];
          if (w == 0) rq0.push_back(r); else rq1.push_back(r);
        end
        last_p = w;
        pend[w].vld = 1'b0;
      end
      if (clr_lvl) begin
        model_idle = 1'b0;
        init_left  = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
    exp_q.push_back(e);
    clr_lvl = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (pend[0].vld || pend[1].vld); k++) do_cycle();
    do_cycle();
  endtask

  task automatic chk_rsp(input int p, input logic vld, input logic [31:0] data, input int c);
    rsp_t r;
    bit   due;
    due = 1'b0;
    r.data = '0;
    if (p == 0 && rq0.size() > 0 && rq0[0].due == c) begin r = rq0.pop_front(); due = 1'b1; end
    if (p == 1 && rq1.size() > 0 && rq1[0].due == c) begin r = rq1.pop_front(); due = 1'b1; end
    chk(p == 1 ? "p1_rsp_vld" : "p0_rsp_vld", 32'(vld), 32'(due), c);
    chk(p == 1 ? "p1_rsp_rdata" : "p0_rsp_rdata", data, r.data, c);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("p0_grnt",   32'(p0_req_grnt), 32'(mon_e.g0), mon_e.cyc);
      chk("p1_grnt",   32'(p1_req_grnt), 32'(mon_e.g1), mon_e.cyc);
      chk("grnt_both", 32'(p0_req_grnt & p1_req_grnt), 32'h0, mon_e.cyc);
      chk("sram_cen",  32'(sram_cen),  32'(mon_e.cen),  mon_e.cyc);
      chk("sram_gwen", 32'(sram_gwen), 32'(mon_e.gwen), mon_e.cyc);
      chk("sram_wen",  sram_wen, mon_e.wen, mon_e.cyc);
      chk("sram_a",    32'(sram_a), 32'(mon_e.a), mon_e.cyc);
      chk("sram_d",    sram_d, mon_e.d, mon_e.cyc);
      chk("init_done", 32'(init_done), 32'(mon_e.done), mon_e.cyc);
      chk_rsp(0, p0_rsp_vld, p0_rsp_rdata, mon_e.cyc);
      chk_rsp(1, p1_rsp_vld, p1_rsp_rdata, mon_e.cyc);
    end
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      pend[p].vld = 1'b0; pend[p].addr = '0; pend[p].wr = 1'b0; pend[p].wdata = '0; pend[p].be = '0;
    end
    cyc_n = 0;
    model_reset();
    #1 cpurst_b = 1'b0;
    rst_lvl = 1'b0;
    repeat (3) do_cycle();

    // power-up fill with requests pending throughout
    rst_lvl = 1'b1;
    rand_en = 1'b1;
    while (!model_idle) do_cycle();
    rand_en = 1'b0;
    drain();

    issue(0, 13'h0010, 1'b1, 32'hA5A5_1234, 4'hF); do_cycle();
    issue(1, 13'h0010, 1'b0, 32'h0, 4'h0);         do_cycle();
    do_cycle();

    issue(0, 13'h0020, 1'b1, 32'hFFFF_FFFF, 4'b0101); do_cycle();
    issue(1, 13'h0020, 1'b0, 32'h0, 4'h0);            do_cycle();
    do_cycle();

    issue(0, 13'h0030, 1'b1, 32'h1357_9BDF, 4'h0); do_cycle();
    issue(0, 13'h0030, 1'b0, 32'h0, 4'h0);         do_cycle();
    do_cycle();

    // sustained contention: both ports always valid
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 2; p++) if (!pend[p].vld) pend[p] = rand_req();
      do_cycle();
    end
    drain();

    rand_en = 1'b1;
    repeat (600) do_cycle();
    rand_en = 1'b0;
    drain();

    // clear taken together with a read; a second clear mid-fill must be ignored
    issue(0, 13'h0005, 1'b1, 32'hDEAD_BEEF, 4'hF); do_cycle();
    issue(0, 13'h0005, 1'b0, 32'h0, 4'h0);
    clr_lvl = 1'b1;
    do_cycle();
    rand_en = 1'b1;
    for (int k = 0; !model_idle && k < 2 * DEPTH; k++) begin
      if (k == 1000) clr_lvl = 1'b1;
      do_cycle();
    end
    rand_en = 1'b0;
    drain();
    issue(0, 13'h0005, 1'b0, 32'h0, 4'h0); do_cycle();
    do_cycle();

    rand_en = 1'b1;
    repeat (300) do_cycle();
    rand_en = 1'b0;
    drain();

    // reset in the middle of a fill
    clr_lvl = 1'b1;
    do_cycle();
    rand_en = 1'b1;
    while (!model_idle && (DEPTH - init_left) < 100) do_cycle();
    rst_lvl = 1'b0;
    repeat (3) do_cycle();
    rst_lvl = 1'b1;
    for (int k = 0; !model_idle && k < 2 * DEPTH; k++) do_cycle();
    repeat (200) do_cycle();
    rand_en = 1'b0;
    drain();
    repeat (3) do_cycle();

    @(negedge clk);
    #1;
    chk("exp_queue_left", 32'(exp_q.size()), 32'h0, cyc_n);
    chk("p0_rsp_left",    32'(rq0.size()),   32'h0, cyc_n);
    chk("p1_rsp_left",    32'(rq1.size()),   32'h0, cyc_n);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "time limit");
  end

endmodule
